// File: rtl/pc_gen.sv
// pc_gen: next-PC selection with exception capture and a circular return-address stack.
module pc_gen #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0180,
  parameter int          RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc,
  input  logic             jr,
  input  logic             ret,
  input  logic             jump,
  input  logic             link,
  input  logic             pcsrc,
  input  logic [15:0]      imm,
  input  logic [25:0]      target,
  input  logic [WIDTH-1:0] rs_val,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);
  localparam int AW = $clog2(RAS_DEPTH);
  logic [WIDTH-1:0] stk [RAS_DEPTH];
  logic [AW-1:0]    wp;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] jt, bt, rt, top;
  logic             push, pop;
  assign pc_plus4  = pc + WIDTH'(4);
  assign ras_empty = cnt == '0;
  assign ras_full  = cnt == (AW+1)'(RAS_DEPTH);
  always_comb begin
    jt        = pc_plus4;
    jt[27:0]  = {target, 2'b00};
    bt        = pc_plus4 + {{(WIDTH-18){imm[15]}}, imm, 2'b00};
    rt        = rs_val & ~WIDTH'(3);
    top       = stk[wp - AW'(1)];
    push      = !exc && !stall && !jr && !ret && jump && link;
    pop       = !exc && !stall && !jr && ret && !ras_empty;
  end
  // wp is the next write slot; when full it also points at the oldest entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= WIDTH'(RESET_VEC);
      epc     <= '0;
      wp      <= '0;
      cnt     <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      ras_unf <= 1'b0;
      if (exc) begin
        pc  <= WIDTH'(EXC_VEC);
        epc <= pc;
      end else if (!stall) begin
        pc      <= jr ? rt : ret ? (ras_empty ? rt : top) : jump ? jt : pcsrc ? bt : pc_plus4;
        ras_unf <= !jr && ret && ras_empty;
        if (push) begin
          wp      <= wp + AW'(1);
          cnt     <= ras_full ? cnt : cnt + (AW+1)'(1);
          ras_ovf <= ras_ovf | ras_full;
        end
        if (pop) begin
          wp  <= wp - AW'(1);
          cnt <= cnt - (AW+1)'(1);
        end
      end
    end
  end
  always_ff @(posedge clk) if (push) stk[wp] <= pc_plus4;
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WIDTH, 32, PC width; legal range 28..64.
- RESET_VEC, 32'h0000_0000, PC value after reset, zero-extended to WIDTH.
- EXC_VEC, 32'h0000_0180, exception target, zero-extended to WIDTH.
- RAS_DEPTH, 4, return-address-stack entries; power of two, 2..16.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all state updates on rising edge.
- reset, in, 1, async active-high reset.
- stall, in, 1, hold PC and stack.
- exc, in, 1, take exception.
- jr, in, 1, jump to register value.
- ret, in, 1, return via stack.
- jump, in, 1, absolute jump.
- link, in, 1, push return address; qualified by jump.
- pcsrc, in, 1, take PC-relative branch.
- imm, in, 16, branch offset in words, signed.
- target, in, 26, jump target in words.
- rs_val, in, WIDTH, register operand for jr and ret fallback.
- pc, out, WIDTH, current PC register.
- pc_plus4, out, WIDTH, combinational pc+4.
- epc, out, WIDTH, PC captured on exception.
- ras_empty, out, 1, stack holds 0 entries.
- ras_full, out, 1, stack holds RAS_DEPTH entries.
- ras_ovf, out, 1, sticky: a push overwrote an entry.
- ras_unf, out, 1, one-cycle pulse: ret taken while empty.

Function
REQ-004 Next-PC priority per edge: exc > stall > jr > ret > jump > pcsrc > sequential.
REQ-005 Sequential: pc <= pc+4, modulo 2^WIDTH (wraps from all-ones-minus-3 to 0).
REQ-006 Branch: pc <= pc+4 + (sign_extend(imm) << 2), modulo 2^WIDTH.
REQ-007 Jump: pc <= {pc_plus4[WIDTH-1:28], target, 2'b00}; for WIDTH=28 the upper field is empty.
REQ-008 jr: pc <= {rs_val[WIDTH-1:2], 2'b00}; stack unchanged.
REQ-009 ret, stack non-empty: pc <= top entry, entry popped, count decrements.
REQ-010 ret, stack empty: pc <= {rs_val[WIDTH-1:2], 2'b00}; ras_unf asserts for the following cycle only; stack unchanged.
REQ-011 jump with link: pc_plus4 pushed in the same edge the jump is taken; link without jump, or when a higher-priority source wins, pushes nothing.
REQ-012 Push when full: circular overwrite of the oldest entry, count stays RAS_DEPTH, ras_ovf set and held until reset.
REQ-013 exc: pc <= EXC_VEC, epc <= current pc, stack untouched; exc overrides stall.
REQ-014 stall (without exc): pc, stack, epc, flags all hold; ras_unf deasserts.
REQ-015 ras_empty/ras_full are registered-state decodes, valid the cycle after any push/pop.
REQ-016 pc_plus4 is combinational from pc; no other output is combinational from inputs.

Reset
REQ-017 On reset assertion, immediately and independent of clk: pc=RESET_VEC, epc=0, stack count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.
REQ-018 Reset asserted mid-operation discards any pending push/pop; the first edge after deassertion performs normal next-PC selection from RESET_VEC.

Verification
REQ-019 Reset then 3 idle edges -> pc 0x0,0x4,0x8,0xC; async reset pulse between edges -> pc=0x0 without a clock edge.
REQ-020 pc=0x10, pcsrc=1, imm=16'hFFFC -> pc=0x04; same with jump=1 simultaneously, target=26'h20 -> pc=0x80 (jump loses to nothing; pcsrc ignored).
REQ-021 pc=0x100, jump=1, link=1, target=26'h40 -> pc=0x100 base cleared: pc=0x00000100? No: pc={0x0,26'h40,00}=0x100 with 0x104 pushed; next ret=1 -> pc=0x104, ras_empty=1.
REQ-022 Five jal pushes (RAS_DEPTH=4) of 0x4,0x8,0xC,0x10,0x14 -> ras_full=1, ras_ovf=1; four rets -> 0x14,0x10,0xC,0x8; fifth ret, rs_val=0x203 -> pc=0x200, ras_unf pulses one cycle.
REQ-023 stall=1 with pcsrc=1 -> pc holds 2 cycles; stall=1 and exc=1 at pc=0x40 -> pc=0x180, epc=0x40, stack count unchanged.
REQ-024 pc=0xFFFF_FFFC, sequential -> pc=0x0000_0000; bench reruns REQ-019..REQ-022 at WIDTH=28 and RAS_DEPTH=2.
